fsm_steer: RTL



---
 rtl/fsm_steer.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/fsm_steer.sv
// fsm_steer: input-side driver for the eight-state, 2-bit-input FSM.
//
// The block owns the FSM's `a` bus and keeps a mirror of the FSM state by
// applying the same transition table to the symbol it drives. On a request
// it drives the shortest symbol sequence into the requested state. It also
// compares the FSM's reported output code against the mirror every cycle.
//
// Request handshake: `start`/`target` are sampled only while idle (busy=0).
// A request for the state the FSM already sits in completes in the same
// cycle (done=1, busy stays 0). Otherwise the first move is driven in the
// request cycle and busy rises on the next cycle. `done` is high exactly in
// the cycle the FSM occupies the target state. While busy, start/target are
// ignored.
//
// Ports:
//   clk        clock shared with the FSM
//   reset      asynchronous, active-high; clears mirror, control and flags
//   start      request strobe (idle only)
//   target     destination state 0..7, sampled with start
//   saida      observed FSM output code
//   a          symbol driven to the FSM (combinational)
//   busy       high while a request is being steered
//   done       high in the cycle the FSM is in the target state
//   err        sticky error (divergence or move budget exhausted)
//   steps      moves taken by the current/last request
//   dbg_mirror mirrored FSM state, for observation only
module fsm_steer #(
   parameter logic [1:0] IDLE_SYM  = 2'd0,
   parameter int         MAX_STEPS = 8
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic [2:0] target,
   input  logic [2:0] saida,
   output logic [1:0] a,
   output logic       busy,
   output logic       done,
   output logic       err,
   output logic [3:0] steps,
   output logic [2:0] dbg_mirror
);

   typedef enum logic {IDLE = 1'b0, RUN = 1'b1} ctl_t;

   ctl_t       ctl;
   logic [2:0] mirror;
   logic [2:0] tgt_q;
   logic [2:0] eff_tgt;
   logic       req_active;

   // Next FSM state for state s under symbol sym.
   function automatic logic [2:0] t_next(input logic [2:0] s, input logic [1:0] sym);
      logic [7:0][2:0] row;   // row[sym], sym 3..0 listed left to right
      case (s)
         3'd0:    row = {12'b0, 3'd5, 3'd1, 3'd3, 3'd1};
         3'd1:    row = {12'b0, 3'd5, 3'd3, 3'd3, 3'd2};
         3'd2:    row = {12'b0, 3'd5, 3'd7, 3'd4, 3'd0};
         3'd3:    row = {12'b0, 3'd5, 3'd2, 3'd2, 3'd0};
         3'd4:    row = {12'b0, 3'd5, 3'd1, 3'd3, 3'd0};
         3'd5:    row = {12'b0, 3'd6, 3'd1, 3'd3, 3'd0};
         3'd6:    row = {12'b0, 3'd3, 3'd1, 3'd3, 3'd0};
         default: row = {12'b0, 3'd5, 3'd1, 3'd2, 3'd0};
      endcase
      return row[{1'b0, sym}];
   endfunction

   // Output code reported by the FSM; state 7 aliases code 3.
   function automatic logic [2:0] code_of(input logic [2:0] s);
      return (s == 3'd7) ? 3'd3 : s;
   endfunction

   // First symbol of a shortest path from s to t, ties to the lowest symbol.
   // Each row lists targets 7..0 left to right.
   function automatic logic [1:0] hop(input logic [2:0] s, input logic [2:0] t);
      logic [7:0][1:0] row;
      case (s)
         3'd0:    row = {2'd0, 2'd3, 2'd3, 2'd0, 2'd1, 2'd0, 2'd0, 2'd0};
         3'd1:    row = {2'd0, 2'd3, 2'd3, 2'd0, 2'd1, 2'd0, 2'd0, 2'd0};
         3'd2:    row = {2'd2, 2'd3, 2'd3, 2'd1, 2'd0, 2'd0, 2'd0, 2'd0};
         3'd3:    row = {2'd1, 2'd3, 2'd3, 2'd1, 2'd0, 2'd1, 2'd0, 2'd0};
         3'd4:    row = {2'd1, 2'd3, 2'd3, 2'd0, 2'd1, 2'd1, 2'd2, 2'd0};
         3'd5:    row = {2'd1, 2'd3, 2'd0, 2'd1, 2'd1, 2'd1, 2'd2, 2'd0};
         3'd6:    row = {2'd1, 2'd0, 2'd0, 2'd1, 2'd1, 2'd1, 2'd2, 2'd0};
         default: row = {2'd0, 2'd3, 2'd3, 2'd1, 2'd0, 2'd1, 2'd2, 2'd0};
      endcase
      return (s == t) ? IDLE_SYM : row[t];
   endfunction

   // A request is being served this cycle: either running, or a fresh
   // start accepted from idle (whose target is used before it is latched).
   assign req_active = (ctl == RUN) || (ctl == IDLE && start);
   assign eff_tgt    = (ctl == IDLE && start) ? target : tgt_q;

   always_comb begin
      a    = IDLE_SYM;
      done = 1'b0;
      if (req_active) begin
         if (mirror == eff_tgt) begin
            done = 1'b1;
         end else begin
            a = hop(mirror, eff_tgt);
         end
      end
   end

   assign busy       = (ctl == RUN);
   assign dbg_mirror = mirror;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         mirror <= 3'd0;
         ctl    <= IDLE;
         tgt_q  <= 3'd0;
         steps  <= 4'd0;
         err    <= 1'b0;
      end else begin
         // The FSM has no self-loops, so the mirror moves every cycle.
         mirror <= t_next(mirror, a);
         if (saida != code_of(mirror)) begin
            // Mirror no longer trustworthy: abort whatever was in flight.
            err <= 1'b1;
            ctl <= IDLE;
         end else begin
            case (ctl)
               IDLE: begin
                  if (start) begin
                     if (mirror == target) begin
                        steps <= 4'd0;
                     end else begin
                        tgt_q <= target;
                        steps <= 4'd1;
                        ctl   <= RUN;
                     end
                  end
               end
               RUN: begin
                  if (mirror == tgt_q) begin
                     ctl <= IDLE;
                  end else if (steps >= 4'(MAX_STEPS)) begin
                     err <= 1'b1;
                     ctl <= IDLE;
                  end else if (steps != 4'hF) begin
                     steps <= steps + 4'd1;
                  end
               end
               default: ctl <= IDLE;
            endcase
         end
      end
   end

endmodule
